// File: rtl/packet_buffer_read_scheduler_if.sv
// Bundle of the descriptor-commit, lane-FIFO read and AXI4-Stream output signals of the
// packet buffer read scheduler.
interface packet_buffer_read_scheduler_if #(
  parameter int unsigned NUM_LANES  = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 11
);
  localparam int unsigned LaneW = $clog2(NUM_LANES);

  logic                            commit_valid_i;
  logic [LaneW-1:0]                commit_lane_i;
  logic [LEN_WIDTH-1:0]            commit_len_i;
  logic                            commit_ready_o;
  logic [NUM_LANES-1:0]            lane_rd_en_o;
  logic [NUM_LANES*DATA_WIDTH-1:0] lane_rd_data_i;
  logic [DATA_WIDTH-1:0]           m_tdata_o;
  logic                            m_tvalid_o;
  logic                            m_tlast_o;
  logic [LaneW-1:0]                m_tlane_o;
  logic                            m_tready_i;
  logic                            busy_o;

  // Scheduler side.
  modport slave (
    input  commit_valid_i, commit_lane_i, commit_len_i, lane_rd_data_i, m_tready_i,
    output commit_ready_o, lane_rd_en_o, m_tdata_o, m_tvalid_o, m_tlast_o, m_tlane_o, busy_o
  );

  // Write path, lane FIFOs and downstream sink.
  modport master (
    output commit_valid_i, commit_lane_i, commit_len_i, lane_rd_data_i, m_tready_i,
    input  commit_ready_o, lane_rd_en_o, m_tdata_o, m_tvalid_o, m_tlast_o, m_tlane_o, busy_o
  );
endinterface

// File: rtl/packet_buffer_read_scheduler.sv
// Queues per-lane packet descriptors and drains whole packets, one lane at a time chosen
// round-robin, from the lane FIFOs onto a single AXI4-Stream master.
module packet_buffer_read_scheduler #(
  parameter int unsigned NUM_LANES  = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 11,
  parameter int unsigned DESC_DEPTH = 4
) (
  input logic                           clk_i,
  input logic                           rst_i,
  packet_buffer_read_scheduler_if.slave bus
);
  localparam int unsigned LaneW = $clog2(NUM_LANES);
  localparam int unsigned PtrW  = $clog2(DESC_DEPTH);
  localparam int unsigned CntW  = $clog2(DESC_DEPTH + 1);

  typedef enum logic {StIdle, StXfer} state_e;

  state_e               state_q, state_d;
  logic [LaneW-1:0]     lane_q, lane_d;
  logic [LaneW-1:0]     last_grant_q, last_grant_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;

  logic [LEN_WIDTH-1:0] desc_q   [NUM_LANES][DESC_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q [NUM_LANES];
  logic [PtrW-1:0]      rd_ptr_q [NUM_LANES];
  logic [CntW-1:0]      occ_q    [NUM_LANES];

  logic                  commit_ready, commit_accept;
  logic                  grant_found, grant;
  logic [LaneW-1:0]      grant_lane, cand;
  logic [NUM_LANES-1:0]  push, pop, rd_en;
  logic                  tvalid, tlast;
  logic [DATA_WIDTH-1:0] tdata;

  // Readiness uses registered occupancy, so a pop in the same cycle cannot free a slot.
  assign commit_ready  = occ_q[bus.commit_lane_i] != CntW'(DESC_DEPTH);
  assign commit_accept = bus.commit_valid_i && commit_ready && (bus.commit_len_i != '0);

  // First non-empty lane after the previous grant.
  always_comb begin
    grant_found = 1'b0;
    grant_lane  = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NUM_LANES; k++) begin
      cand = LaneW'((32'(last_grant_q) + k) % NUM_LANES);
      if (!grant_found && occ_q[cand] != '0) begin
        grant_found = 1'b1;
        grant_lane  = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    last_grant_d = last_grant_q;
    remaining_d  = remaining_q;
    grant        = 1'b0;
    tvalid       = 1'b0;
    tlast        = 1'b0;
    tdata        = '0;
    rd_en        = '0;
    case (state_q)
      StIdle: begin
        if (grant_found) begin
          grant        = 1'b1;
          lane_d       = grant_lane;
          last_grant_d = grant_lane;
          remaining_d  = desc_q[grant_lane][rd_ptr_q[grant_lane]];
          state_d      = StXfer;
        end
      end
      StXfer: begin
        tvalid = 1'b1;
        tlast  = remaining_q == LEN_WIDTH'(1);
        tdata  = bus.lane_rd_data_i[32'(lane_q)*DATA_WIDTH +: DATA_WIDTH];
        if (bus.m_tready_i) begin
          rd_en[lane_q] = 1'b1;
          if (remaining_q != '0) remaining_d = remaining_q - 1'b1;
          if (tlast) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    push = '0;
    pop  = '0;
    if (commit_accept) push[bus.commit_lane_i] = 1'b1;
    if (grant) pop[grant_lane] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      lane_q       <= '0;
      last_grant_q <= LaneW'(NUM_LANES - 1);
      remaining_q  <= '0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      last_grant_q <= last_grant_d;
      remaining_q  <= remaining_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        wr_ptr_q[l] <= '0;
        rd_ptr_q[l] <= '0;
        occ_q[l]    <= '0;
      end
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (push[l]) wr_ptr_q[l] <= wr_ptr_q[l] + 1'b1;
        if (pop[l]) rd_ptr_q[l] <= rd_ptr_q[l] + 1'b1;
        if (push[l] && !pop[l]) begin
          occ_q[l] <= occ_q[l] + 1'b1;
        end else if (pop[l] && !push[l]) begin
          occ_q[l] <= occ_q[l] - 1'b1;
        end
      end
    end
  end

  // Descriptor storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (push[l]) desc_q[l][wr_ptr_q[l]] <= bus.commit_len_i;
    end
  end

  assign bus.commit_ready_o = commit_ready;
  assign bus.lane_rd_en_o   = rd_en;
  assign bus.m_tdata_o      = tdata;
  assign bus.m_tvalid_o     = tvalid;
  assign bus.m_tlast_o      = tlast;
  assign bus.m_tlane_o      = lane_q;
  assign bus.busy_o         = state_q == StXfer;
endmodule
